// File: rtl/prog_counter_pkg.sv
// Shared types and default constants for the program counter block.
// The optional return-address stack is selected with PROG_COUNTER_RAS_EN.
package prog_counter_pkg;

    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_RESET_VEC = 0;
    localparam int DEF_RAS_DEPTH = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        RET    = 3'd1,
        CALL   = 3'd2,
        JUMP   = 3'd3,
        BRANCH = 3'd4,
        INC    = 3'd5
    } sel_t;

endpackage

// File: rtl/prog_counter_ras.sv
// Return-address stack (module pc_ras): LIFO of DEPTH entries with full/empty flags.
// Only the occupancy count is reset; stale entries beyond it are never read.
module pc_ras #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] push_data,
    output logic [DATA_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0]     count;
    logic [IW-1:0]     wr_idx;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] mem [DEPTH];

    assign full   = (count == CW'(DEPTH));
    assign empty  = (count == '0);
    assign wr_idx = IW'(count);
    assign rd_idx = empty ? '0 : IW'(count - CW'(1));
    assign top    = mem[rd_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CW'(1);
        end else if (pop && !empty) begin
            count <= count - CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Program counter with halt, stall, jump, relative branch and optional call/return
// stack (define PROG_COUNTER_RAS_EN to build the stack and the ras_err flag).
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int RESET_VEC = DEF_RESET_VEC,
    parameter int RAS_DEPTH = DEF_RAS_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     encerra,
    input  logic                     stall,
    input  logic                     jump,
    input  logic        [ADDR_W-1:0] jump_addr,
    input  logic                     branch,
    input  logic signed [ADDR_W-1:0] branch_off,
    input  logic                     call,
    input  logic                     ret,
    output logic        [ADDR_W-1:0] pc_out,
    output logic                     halted,
    output logic                     ras_err
);

    localparam logic [ADDR_W-1:0] RST_PC = ADDR_W'(RESET_VEC);

    state_t            state;
    state_t            state_next;
    sel_t              sel;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] pc_branch;

    assign pc_inc    = pc_out + ADDR_W'(1);
    assign pc_branch = pc_out + $unsigned(branch_off);
    assign halted    = (state == HALTED);

`ifdef PROG_COUNTER_RAS_EN
    logic              push;
    logic              pop;
    logic              err_set;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_full;
    logic              ras_empty;

    pc_ras #(
        .DATA_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc_inc),
        .top       (ras_top),
        .full      (ras_full),
        .empty     (ras_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ras_err <= 1'b0;
        end else if (err_set) begin
            ras_err <= 1'b1;
        end
    end
`else
    // Without the stack, ret has no effect and the depth is irrelevant.
    logic unused_ras;
    assign unused_ras = ret ^ (RAS_DEPTH < 2);
    assign ras_err    = 1'b0;
`endif

    always_comb begin
        state_next = state;
        sel        = INC;
`ifdef PROG_COUNTER_RAS_EN
        push       = 1'b0;
        pop        = 1'b0;
        err_set    = 1'b0;
`endif
        if (state == HALTED) begin
            sel = HOLD;
        end else if (encerra) begin
            sel        = HOLD;
            state_next = HALTED;
        end else if (stall) begin
            sel = HOLD;
`ifdef PROG_COUNTER_RAS_EN
        end else if (ret) begin
            // Underflow falls back to a plain increment, not to call/jump.
            if (ras_empty) begin
                sel     = INC;
                err_set = 1'b1;
            end else begin
                sel = RET;
                pop = 1'b1;
            end
        end else if (call) begin
            sel = CALL;
            if (ras_full) begin
                err_set = 1'b1;
            end else begin
                push = 1'b1;
            end
`else
        end else if (call) begin
            sel = CALL;
`endif
        end else if (jump) begin
            sel = JUMP;
        end else if (branch) begin
            sel = BRANCH;
        end else begin
            sel = INC;
        end
    end

    always_comb begin
        pc_next = pc_out;
        case (sel)
            HOLD:   pc_next = pc_out;
`ifdef PROG_COUNTER_RAS_EN
            RET:    pc_next = ras_top;
`endif
            CALL:   pc_next = jump_addr;
            JUMP:   pc_next = jump_addr;
            BRANCH: pc_next = pc_branch;
            INC:    pc_next = pc_inc;
            default: pc_next = pc_out;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            pc_out <= RST_PC;
        end else begin
            state  <= state_next;
            pc_out <= pc_next;
        end
    end

endmodule
